div_controller: RTL and testbench

//  Sequencer for the iterative restoring divider used by the DIV instruction. Accepts a start pulse with

---
 rtl/cpu_pkg.sv | 16 +
 rtl/div_step.sv | 29 ++
 rtl/div_controller.sv | 147 ++++++++++++++
 tb/tb_div_controller.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the divide sequencer and its datapath step.
package cpu_pkg;

  // Default operand/result width of the integer datapath.
  localparam int DIV_WIDTH = 32;

  // Divider sequencer states.
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ITER,
    FIXUP,
    DONE
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step on the partial remainder A,
// the quotient/dividend shift register Q and the divisor magnitude M.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   a_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH:0]   a_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0] a_sh;
  logic [WIDTH:0] trial;

  // Shift {A,Q} left, try subtracting M, keep or restore depending on the sign.
  always_comb begin
    a_sh  = {a_i[WIDTH-1:0], q_i[WIDTH-1]};
    trial = a_sh - {1'b0, m_i};
    if (trial[WIDTH]) begin
      a_o = a_sh;
      q_o = {q_i[WIDTH-2:0], 1'b0};
    end else begin
      a_o = trial;
      q_o = {q_i[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_controller.sv
// Sequencer for the iterative signed restoring divider behind the DIV
// instruction: captures operands, runs WIDTH restoring steps on magnitudes,
// restores signs and presents quotient (LO) and remainder (HI) with a done pulse.
module div_controller
  import cpu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   a_step;
  logic [WIDTH-1:0] q_step;

  div_step #(.WIDTH(WIDTH)) u_step (
    .a_i (a_q),
    .q_i (q_q),
    .m_i (m_q),
    .a_o (a_step),
    .q_o (q_step)
  );

  // Next-state and datapath updates for every state.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    state_d   = state_q;
    count_d   = count_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    a_d       = a_q;
    q_d       = q_q;
    m_d       = m_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dz_d      = dz_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d     = dividend;
          dvs_d     = divisor;
          neg_quo_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          neg_rem_d = dividend[WIDTH-1];
          dz_d      = 1'b0;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        // Magnitudes are unsigned, so the most negative operand fits as 2^(WIDTH-1).
        a_d     = '0;
        q_d     = dvd_q[WIDTH-1] ? -dvd_q : dvd_q;
        m_d     = dvs_q[WIDTH-1] ? -dvs_q : dvs_q;
        count_d = '0;
        // A zero divisor skips the iterations; FIXUP substitutes the defined result.
        state_d = (dvs_q == '0) ? FIXUP : ITER;
      end
      ITER: begin
        a_d     = a_step;
        q_d     = q_step;
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(WIDTH - 1)) begin
          state_d = FIXUP;
        end
      end
      FIXUP: begin
        if (m_q == '0) begin
          quo_d = '1;
          rem_d = dvd_q;
          dz_d  = 1'b1;
        end else begin
          quo_d = neg_quo_q ? -q_q : q_q;
          rem_d = neg_rem_q ? -a_q[WIDTH-1:0] : a_q[WIDTH-1:0];
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      a_q       <= '0;
      q_q       <= '0;
      m_q       <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      a_q       <= a_d;
      q_q       <= q_d;
      m_q       <= m_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dz_q      <= dz_d;
    end
  end

  assign busy      = (state_q == LOAD) || (state_q == ITER) || (state_q == FIXUP);
  assign done      = (state_q == DONE);
  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_div_controller.sv
// Self-checking bench for div_controller: directed cases, ignored starts,
// mid-division reset and a random signed sweep against a truncating-division model.
module tb_div_controller;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;

  typedef struct {
    logic [W-1:0] quo;
    logic [W-1:0] rem;
    logic         dz;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  div_controller dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: truncating signed division with the defined special cases.
  function automatic exp_t model(input logic [W-1:0] dvd, input logic [W-1:0] dvs);
    exp_t e;
    if (dvs == '0) begin
      e.quo = '1;
      e.rem = dvd;
      e.dz  = 1'b1;
    end else if (dvd == 32'h8000_0000 && dvs == 32'hFFFF_FFFF) begin
      e.quo = 32'h8000_0000;
      e.rem = '0;
      e.dz  = 1'b0;
    end else begin
      e.quo = $signed(dvd) / $signed(dvs);
      e.rem = $signed(dvd) % $signed(dvs);
      e.dz  = 1'b0;
    end
    return e;
  endfunction

  // One division; extra start pulses are driven p1/p2 cycles after acceptance.
  task automatic run_op(input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                        input int p1, input int p2);
    exp_t e;
    int   k;
    bit   got;
    int   lat_exp;
    sb_q.push_back(model(dvd, dvs));
    lat_exp = (dvs == '0) ? 2 : W + 2;
    @(posedge clock);
    #1 dividend = dvd; divisor = dvs; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0; dividend = $urandom; divisor = $urandom;
    @(negedge clock);
    check("busy_after_start", busy, 1);
    check("dz_cleared_on_start", div_zero, 0);
    k = 0;
    got = 0;
    while (!got && k < 100) begin
      @(posedge clock);
      k++;
      #1 start = (k == p1 || k == p2);
      if (start) begin
        dividend = 32'd999;
        divisor  = 32'd3;
      end
      @(negedge clock);
      if (done) got = 1;
    end
    start = 1'b0;
    check("latency", k, lat_exp);
    e = sb_q.pop_front();
    if (got) begin
      check("quotient", quotient, e.quo);
      check("remainder", remainder, e.rem);
      check("div_zero", div_zero, e.dz);
      check("busy_low_in_done", busy, 0);
      @(negedge clock);
      check("done_one_cycle", done, 0);
    end
  endtask

  initial begin
    int extra;
    reset_n  = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_div_zero", div_zero, 0);
    #1 reset_n = 1'b1;

    run_op(32'd100, 32'd7, -1, -1);
    check("hold_quotient_idle", quotient, 32'd14);
    run_op(-32'sd100, 32'd7, -1, -1);
    run_op(32'd100, -32'sd7, -1, -1);
    run_op(32'd7, 32'd0, -1, -1);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
    run_op(32'd5, 32'd9, -1, -1);
    run_op(32'h8000_0000, 32'd0, -1, -1);
    run_op(32'h7FFF_FFFF, 32'h8000_0000, -1, -1);

    // Start pulses during a running division are ignored; no second done follows.
    run_op(32'd100, 32'd7, 5, 20);
    extra = 0;
    repeat (40) begin
      @(negedge clock);
      if (done) extra++;
    end
    check("no_queued_done", extra, 0);

    // Reset in the middle of the iterations clears everything.
    @(posedge clock);
    #1 dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (11) @(posedge clock);
    #1 reset_n = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_quotient", quotient, 0);
    check("mid_rst_remainder", remainder, 0);
    check("mid_rst_div_zero", div_zero, 0);
    #1 reset_n = 1'b1;
    extra = 0;
    repeat (40) begin
      @(negedge clock);
      if (done) extra++;
    end
    check("no_done_after_rst", extra, 0);
    run_op(32'd1000, 32'd3, -1, -1);

    // Random signed sweep mixing full-range and small divisors.
    for (int i = 0; i < 500; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = $urandom_range(0, 20);
        2: b = -$urandom_range(1, 20);
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      if (i % 5 == 0) a = a >> $urandom_range(0, 31);
      run_op(a, b, -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
